// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and hex-to-seven-segment table
// for the sequential ALU with hex display.
`default_nettype none

package alu_seq_pkg;

  localparam logic [3:0] OP_PASS  = 4'd0;
  localparam logic [3:0] OP_NEG   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_SHL1  = 4'd4;
  localparam logic [3:0] OP_SHR1  = 4'd5;
  localparam logic [3:0] OP_INC   = 4'd6;
  localparam logic [3:0] OP_DEC   = 4'd7;
  localparam logic [3:0] OP_NOT   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_AND   = 4'd10;
  localparam logic [3:0] OP_XOR   = 4'd11;
  localparam logic [3:0] OP_OR    = 4'd12;
  localparam logic [3:0] OP_ASR1  = 4'd13;
  localparam logic [3:0] OP_DIV   = 4'd14;
  localparam logic [3:0] OP_CONST = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Segment order is a..g from MSB to LSB, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_hexdisp_scan.sv
// hex7seg_scan: time-multiplexed hex display of a DATA_W-bit value,
// one digit shown for REFRESH_DIV cycles, digit 0 first.
`default_nettype none

module hex7seg_scan
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  output logic [6:0]            seg,
  output logic [DATA_W/4-1:0]   bank
);

  localparam int NDIG  = DATA_W / 4;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NDIG - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nib = value[3:0];
    for (int i = 1; i < NDIG; i++) begin
      if (idx == IDX_W'(i)) nib = value[4*i +: 4];
    end
  end

  assign seg  = hex_to_seg(nib);
  assign bank = NDIG'(1) << idx;

endmodule

`default_nettype wire

// File: rtl/alu_seq_hexdisp.sv
// alu_seq_hexdisp: memory-operand ALU with start/done handshake, iterative
// MUL/DIV, result/flag registers and a scanned hex display of the result.
`default_nettype none

module alu_seq_hexdisp
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          op,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [ADDR_W-1:0]   addr_b,
  output logic [ADDR_W-1:0]   mem_addr_a,
  output logic [ADDR_W-1:0]   mem_addr_b,
  input  logic [DATA_W-1:0]   mem_data_a,
  input  logic [DATA_W-1:0]   mem_data_b,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   result,
  output logic                carry,
  output logic                zero,
  output logic                ovf,
  output logic [6:0]          seg,
  output logic [DATA_W/4-1:0] bank
);

  localparam int ITER_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MSB_ONLY = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS  = ~MSB_ONLY;
  localparam logic [DATA_W:0]   ONE_X    = (DATA_W+1)'(1);

  state_t            state, state_nx;
  logic [3:0]        op_q;
  logic [ITER_W-1:0] iter;
  logic [DATA_W-1:0] hi_q, lo_q, m_q;

  logic              is_mul, is_iter, last_iter;
  logic [DATA_W-1:0] a, b, alu_res;
  logic              alu_c, alu_v;
  logic [DATA_W-1:0] hi_in, lo_in, m_in, hi_nx, lo_nx;
  logic [DATA_W:0]   mul_sum, rem_sh, rem_diff;
  logic              ge;

  assign is_mul    = (op_q == OP_MUL);
  assign is_iter   = is_mul || (op_q == OP_DIV);
  assign last_iter = (iter == ITER_W'(DATA_W - 1));

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = FETCH;
      end
      FETCH: state_nx = EXEC;
      EXEC:  if (!is_iter || last_iter) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    a       = mem_data_a;
    b       = mem_data_b;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_PASS: alu_res = a;
      OP_NEG: begin
        alu_res = '0 - a;
        alu_v   = (a == MSB_ONLY);
      end
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
        alu_v = (a[DATA_W-1] == b[DATA_W-1]) && (alu_res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        {alu_c, alu_res} = {1'b0, a} - {1'b0, b};
        alu_v = (a[DATA_W-1] != b[DATA_W-1]) && (alu_res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SHL1: begin
        alu_res = {a[DATA_W-2:0], 1'b0};
        alu_c   = a[DATA_W-1];
      end
      OP_SHR1: alu_res = {1'b0, a[DATA_W-1:1]};
      OP_INC: begin
        {alu_c, alu_res} = {1'b0, a} + ONE_X;
        alu_v = (a == MAX_POS);
      end
      OP_DEC: begin
        {alu_c, alu_res} = {1'b0, a} - ONE_X;
        alu_v = (a == MSB_ONLY);
      end
      OP_NOT:   alu_res = ~a;
      OP_AND:   alu_res = a & b;
      OP_XOR:   alu_res = a ^ b;
      OP_OR:    alu_res = a | b;
      OP_ASR1:  alu_res = {a[DATA_W-1], a[DATA_W-1:1]};
      OP_CONST: alu_res = '1;
      default:  alu_res = '0;
    endcase
  end

  // MUL: shift-add over {hi,lo} with the multiplier in lo.
  // DIV: restoring division, remainder in hi, dividend/quotient shifting through lo.
  always_comb begin
    hi_in    = (iter == '0) ? '0 : hi_q;
    lo_in    = (iter == '0) ? (is_mul ? mem_data_b : mem_data_a) : lo_q;
    m_in     = (iter == '0) ? (is_mul ? mem_data_a : mem_data_b) : m_q;
    mul_sum  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, m_in} : '0);
    rem_sh   = {hi_in, lo_in[DATA_W-1]};
    rem_diff = rem_sh - {1'b0, m_in};
    ge       = !rem_diff[DATA_W];
    if (is_mul) begin
      hi_nx = mul_sum[DATA_W:1];
      lo_nx = {mul_sum[0], lo_in[DATA_W-1:1]};
    end else begin
      hi_nx = ge ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
      lo_nx = {lo_in[DATA_W-2:0], ge};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_PASS;
      mem_addr_a <= '0;
      mem_addr_b <= '0;
      iter       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      result     <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        op_q       <= op;
        mem_addr_a <= addr_a;
        mem_addr_b <= addr_b;
        iter       <= '0;
      end
      if (state == EXEC) begin
        if (is_iter) begin
          hi_q <= hi_nx;
          lo_q <= lo_nx;
          m_q  <= m_in;
          iter <= iter + ITER_W'(1);
          if (last_iter) begin
            result <= lo_nx;
            carry  <= is_mul && (|hi_nx);
            zero   <= (lo_nx == '0);
            ovf    <= !is_mul && (m_in == '0);
          end
        end else begin
          result <= alu_res;
          carry  <= alu_c;
          zero   <= (alu_res == '0);
          ovf    <= alu_v;
        end
      end
    end
  end

  hex7seg_scan #(
    .DATA_W      (DATA_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .value (result),
    .seg   (seg),
    .bank  (bank)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_hexdisp.sv
// tb_alu_seq_hexdisp: directed stimulus with a queue of expected results
// matched against each done pulse.
`timescale 1ns/1ps

module tb_alu_seq_hexdisp;

  localparam int W    = 8;
  localparam int AW   = 4;
  localparam int RD   = 4;
  localparam int NDIG = W / 4;

  localparam logic [3:0] T_NEG = 4'd1, T_ADD = 4'd2, T_SUB = 4'd3, T_SHL1 = 4'd4,
                         T_INC = 4'd6, T_DEC = 4'd7, T_MUL = 4'd9, T_XOR = 4'd11,
                         T_ASR1 = 4'd13, T_DIV = 4'd14, T_CONST = 4'd15;

  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] op;
  logic [AW-1:0] addr_a, addr_b, mem_addr_a, mem_addr_b;
  logic [W-1:0] mem_data_a, mem_data_b, result;
  logic busy, done, carry, zero, ovf;
  logic [6:0] seg;
  logic [NDIG-1:0] bank;

  alu_seq_hexdisp #(.DATA_W(W), .ADDR_W(AW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .addr_a(addr_a), .addr_b(addr_b),
    .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
    .busy(busy), .done(done), .result(result),
    .carry(carry), .zero(zero), .ovf(ovf),
    .seg(seg), .bank(bank)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [16];
  always @(posedge clk) begin
    mem_data_a <= mem[mem_addr_a];
    mem_data_b <= mem[mem_addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         c, z, v;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t got;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        got = q.pop_front();
        check({got.tag, "_result"}, result, got.res);
        check({got.tag, "_carry"}, carry, got.c);
        check({got.tag, "_zero"}, zero, got.z);
        check({got.tag, "_ovf"}, ovf, got.v);
        check({got.tag, "_latency"}, cyc, got.cyc);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("idle_timeout", busy, 32'd0);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drained"}, q.size(), 32'd0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [W-1:0] r, input logic c, input logic z, input logic v,
                        input bit multi, input bit poke);
    exp_t e;
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = o; addr_a = a; addr_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    e.tag = tag; e.res = r; e.c = c; e.z = z; e.v = v;
    e.cyc = cyc + (multi ? W + 1 : 2);
    q.push_back(e);
    if (poke) begin
      @(negedge clk);
      start = 1'b1; op = T_CONST;
      @(negedge clk);
      start = 1'b0;
    end
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NDIG-1:0] prev;
    logic [NDIG-1:0] eb;
    logic [6:0]      es;
    bit              found;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[3] = 8'h7F; mem[5] = 8'h01; mem[6] = 8'h10; mem[7] = 8'h00;
    mem[8] = 8'h80; mem[9] = 8'hFF; mem[10] = 8'hC8; mem[11] = 8'h07; mem[12] = 8'h0B;

    rst = 1'b1; start = 1'b0; op = '0; addr_a = '0; addr_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry, zero, ovf}, 0);
    check("rst_mem_addr", {mem_addr_a, mem_addr_b}, 0);
    check("rst_bank", bank, 1);
    check("rst_seg", seg, 7'b0000001);

    run_op("add", T_ADD, 4'd3, 4'd5, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Lock onto the digit-1 -> digit-0 transition, then follow one full scan.
    prev = bank; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (prev == 2'b10 && bank == 2'b01) found = 1'b1;
      else prev = bank;
    end
    check("disp_sync", found, 1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      eb = (k >= 4 && k < 8) ? 2'b10 : 2'b01;
      es = (k >= 4 && k < 8) ? 7'b0000000 : 7'b0000001;
      check("disp_bank", bank, eb);
      check("disp_seg", seg, es);
    end

    run_op("sub_poke", T_SUB, 4'd5, 4'd3, 8'h82, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("mul_16x16", T_MUL, 4'd6, 4'd6, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("div_by0", T_DIV, 4'd3, 4'd7, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("mul_11x7", T_MUL, 4'd12, 4'd11, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("div_200_7", T_DIV, 4'd10, 4'd11, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort a multiply in its fourth EXEC cycle.
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = T_MUL; addr_a = 4'd6; addr_b = 4'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_flags", {carry, zero, ovf}, 0);
    check("abort_mem_addr", mem_addr_a, 0);
    repeat (12) @(negedge clk);

    run_op("add_after_abort", T_ADD, 4'd3, 4'd5, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("neg_min", T_NEG, 4'd8, 4'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("inc_ff", T_INC, 4'd9, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("shl1_80", T_SHL1, 4'd8, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("asr1_80", T_ASR1, 4'd8, 4'd0, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("dec_00", T_DEC, 4'd7, 4'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("xor", T_XOR, 4'd3, 4'd9, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("const", T_CONST, 4'd0, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_hexdisp.md
Name: alu_seq_hexdisp

Overview:
- Parametrised, sequential successor to the team's 4-bit memory-operand ALU.
- Fetches two DATA_W-bit operands from an external synchronous-read operand memory and executes one of 16 opcodes under a start/done handshake.
- Iterative multiply and divide take multiple cycles.
- Holds the result with flags and drives a time-multiplexed NDIG-digit hex seven-segment display for board-level debug.

Parameters:
- DATA_W, 8, operand/result width; multiple of 4, range 4..16.
- ADDR_W, 4, operand memory address width.
- NDIG, DATA_W/4, number of display digits (derived; never overridden).
- REFRESH_DIV, 1024, clk cycles each digit is shown; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  opcode.
- addr_a  in  ADDR_W  operand A address.
- addr_b  in  ADDR_W  operand B address.
- mem_addr_a  out  ADDR_W  registered address to memory port A.
- mem_addr_b  out  ADDR_W  registered address to memory port B.
- mem_data_a  in  DATA_W  port A data, valid 1 cycle after its address.
- mem_data_b  in  DATA_W  port B data, valid 1 cycle after its address.
- busy  out  1  high in FETCH/EXEC/DONE.
- done  out  1  one-cycle pulse when result/flags update.
- result  out  DATA_W  registered result.
- carry  out  1  carry-out / borrow / multiply high-part nonzero.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow, or divide-by-zero.
- seg  out  7  segments a..g, active-low (hex 0 = 0000001).
- bank  out  NDIG  one-hot digit enable, active-high.

Behaviour:
- Reset values: FSM IDLE; busy=0, done=0, result=0, carry=0, zero=0, ovf=0, mem_addr_*=0; refresh counter 0, digit index 0, bank=1, seg=0000001.
- IDLE: when start=1, latch op/addr_a/addr_b and go to FETCH. start is ignored in all other states.
- FETCH (1 cycle): mem_addr_* hold the latched addresses; go to EXEC.
- EXEC: operands come from mem_data_*.
  - Single-cycle opcodes: compute, then go to DONE.
  - MUL/DIV: run DATA_W iterations, one per cycle, then go to DONE.
- DONE (1 cycle): result and flags registered; done=1; return to IDLE.
- Latency: start sampled at edge N → done high in cycle N+3 for single-cycle opcodes, N+2+DATA_W for MUL/DIV. Back-to-back start is accepted in the cycle after DONE.
- result and flags hold until the next DONE.
- Opcodes, width DATA_W, wrap modulo 2^DATA_W:
  - 0 PASS A
  - 1 NEG (−A)
  - 2 ADD A+B
  - 3 SUB A−B (carry=borrow)
  - 4 SHL1 (carry=A msb)
  - 5 SHR1 logical
  - 6 INC
  - 7 DEC (carry=borrow)
  - 8 NOT
  - 9 MUL, low DATA_W bits; shift-add; carry = upper half nonzero
  - 10 AND
  - 11 XOR
  - 12 OR
  - 13 ASR1
  - 14 DIV unsigned quotient; restoring; B=0 → result all-ones, ovf=1, no iterations skipped
  - 15 CONST all-ones
- ovf rules: set only for NEG/ADD/SUB/INC/DEC on two's-complement overflow, and for DIV by 0. NEG of the most-negative value gives ovf=1.
- carry is 0 for opcodes not listed above as setting it. zero is evaluated for every opcode.
- rst mid-operation: abort immediately; all outputs go to reset values; no done pulse.
- Display:
  - Shows the result register.
  - Counter counts 0..REFRESH_DIV−1, then wraps. On wrap, the digit index advances 0..NDIG−1, then wraps to 0.
  - bank = 1<<index; seg = hex encoding of result[4*index+3 : 4*index].
  - Display is never blanked; a result update is visible on the next displayed digit.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_PASS..OP_CONST;
  - FSM state encoding IDLE/FETCH/EXEC/DONE;
  - function hex_to_seg(4-bit) → 7-bit, active-low, table 0..F.
- Sub-module hex7seg_scan(clk, rst, value[DATA_W], seg, bank), parametrised by DATA_W and REFRESH_DIV.

Test Plan:
- DATA_W=8, mem[3]=0x7F, mem[5]=0x01; ADD a=3 b=5 → done at N+3, result=0x80, carry=0, ovf=1, zero=0.
- SUB a=5 b=3 → result=0x82, carry=1, ovf=0; start pulsed during busy is ignored (exactly one done).
- mem[6]=0x10; MUL a=6 b=6 → done at N+10, result=0x00, carry=1, zero=1; then DIV a=3 b=7 with mem[7]=0 → result=0xFF, ovf=1, done at N+10.
- rst asserted in the 4th EXEC cycle of MUL → next cycle busy=0, result=0, flags 0, no done; a following ADD completes normally.
- REFRESH_DIV=4, result=0x80 → bank=01 with seg=0000001 for 4 cycles, then bank=10 with seg=0000000 for 4 cycles, then wraps to bank=01.
- NEG on mem[8]=0x80 → result=0x80, ovf=1; INC on 0xFF → result=0x00, carry=1, zero=1.
